// File: rtl/shape_rect_writer_pkg.sv
// Shared frame constants and FSM encoding for the rectangle test-image writer.
package shape_rect_writer_pkg;

    localparam int unsigned XSZ     = 3;
    localparam int unsigned YSZ     = 3;
    localparam int unsigned ADDR_SZ = 6;
    localparam int unsigned COL_SZ  = 3;
    localparam int unsigned WIDTH   = 6;
    localparam int unsigned HEIGHT  = 6;
    localparam int unsigned NPIX    = WIDTH * HEIGHT;

    // Finders treat pixels above this value as foreground.
    localparam logic [COL_SZ-1:0] THRESHOLD = '0;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StClear,
        StFill,
        StFinish
    } state_e;

endpackage

// File: rtl/shape_rect_writer_if.sv
// Request/completion handshake and RAM write port of the rectangle writer.
interface shape_rect_writer_if;
    import shape_rect_writer_pkg::*;

    logic                start;
    logic [YSZ-1:0]      top;
    logic [YSZ-1:0]      bottom;
    logic [XSZ-1:0]      left;
    logic [XSZ-1:0]      right;
    logic [COL_SZ-1:0]   colour;
    logic [COL_SZ-1:0]   bg_colour;
    logic [ADDR_SZ-1:0]  mem_address;
    logic [COL_SZ-1:0]   mem_data;
    logic                mem_wren;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output start, top, bottom, left, right, colour, bg_colour,
        input  mem_address, mem_data, mem_wren, busy, done, err
    );

    modport slave (
        input  start, top, bottom, left, right, colour, bg_colour,
        output mem_address, mem_data, mem_wren, busy, done, err
    );

endinterface

// File: rtl/shape_rect_writer_address_translator.sv
// Maps a pixel (x, y) to its linear RAM address y*WIDTH + x.
module address_translator
    import shape_rect_writer_pkg::*;
(
    input  logic [XSZ-1:0]     x_i,
    input  logic [YSZ-1:0]     y_i,
    output logic [ADDR_SZ-1:0] addr_o
);
    logic [ADDR_SZ-1:0] y_ext;
    logic [ADDR_SZ-1:0] x_ext;

    assign y_ext  = ADDR_SZ'(y_i);
    assign x_ext  = ADDR_SZ'(x_i);
    // y*6 as y*4 + y*2, avoiding a multiplier.
    assign addr_o = (y_ext << 2) + (y_ext << 1) + x_ext;

endmodule

// File: rtl/shape_rect_writer.sv
// Clears the 6x6 frame to a background colour, then paints a filled rectangle.
module shape_rect_writer
    import shape_rect_writer_pkg::*;
(
    input logic              clk,
    input logic              resetn,
    shape_rect_writer_if.slave bus
);
    localparam logic [XSZ-1:0]     XLast = XSZ'(WIDTH - 1);
    localparam logic [YSZ-1:0]     YLast = YSZ'(HEIGHT - 1);
    localparam logic [ADDR_SZ-1:0] CLast = ADDR_SZ'(NPIX - 1);

    state_e              state_q;
    logic [YSZ-1:0]      top_q, bottom_q, y_q;
    logic [XSZ-1:0]      left_q, right_q, x_q;
    logic [COL_SZ-1:0]   colour_q, bg_q;
    logic [ADDR_SZ-1:0]  c_q;
    logic                reject_q, busy_q, done_q, err_q;

    logic                reject;
    logic [ADDR_SZ-1:0]  fill_addr;
    logic [ADDR_SZ-1:0]  mem_address;
    logic [COL_SZ-1:0]   mem_data;
    logic                mem_wren;

    assign reject = (left_q > right_q) || (top_q > bottom_q) ||
                    (right_q > XLast) || (bottom_q > YLast);

    address_translator u_xlat (
        .x_i    (x_q),
        .y_i    (y_q),
        .addr_o (fill_addr)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            top_q    <= '0;
            bottom_q <= '0;
            left_q   <= '0;
            right_q  <= '0;
            colour_q <= '0;
            bg_q     <= '0;
            c_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        top_q    <= bus.top;
                        bottom_q <= bus.bottom;
                        left_q   <= bus.left;
                        right_q  <= bus.right;
                        colour_q <= bus.colour;
                        bg_q     <= bus.bg_colour;
                        busy_q   <= 1'b1;
                        state_q  <= StCheck;
                    end
                end
                StCheck: begin
                    reject_q <= reject;
                    c_q      <= '0;
                    state_q  <= reject ? StFinish : StClear;
                end
                StClear: begin
                    c_q <= c_q + 1'b1;
                    if (c_q == CLast) begin
                        c_q     <= '0;
                        x_q     <= left_q;
                        y_q     <= top_q;
                        state_q <= StFill;
                    end
                end
                StFill: begin
                    if (x_q == right_q) begin
                        x_q <= left_q;
                        // y is left at bottom on exit so it never leaves the frame.
                        if (y_q == bottom_q) state_q <= StFinish;
                        else                 y_q     <= y_q + 1'b1;
                    end else begin
                        x_q <= x_q + 1'b1;
                    end
                end
                StFinish: begin
                    done_q   <= 1'b1;
                    err_q    <= reject_q;
                    busy_q   <= 1'b0;
                    reject_q <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        mem_wren    = 1'b0;
        mem_address = '0;
        mem_data    = '0;
        unique case (state_q)
            StClear: begin
                mem_wren    = 1'b1;
                mem_address = c_q;
                mem_data    = bg_q;
            end
            StFill: begin
                mem_wren    = 1'b1;
                mem_address = fill_addr;
                mem_data    = colour_q;
            end
            default: ;
        endcase
    end

    assign bus.mem_wren    = mem_wren;
    assign bus.mem_address = mem_address;
    assign bus.mem_data    = mem_data;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_shape_rect_writer.sv
// Self-checking bench: per-scenario tasks compared against a frame-level write model.
module tb_shape_rect_writer;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    shape_rect_writer_if bus ();

    shape_rect_writer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_addr[$];
    int exp_data[$];
    int exp_lat;
    int exp_err;

    int obs_addr[$];
    int obs_data[$];
    int done_cyc, ndone, err_obs, busy_start, busy_after;
    int rst_wren, rst_busy, rst_done;

    // Reference: full clear in address order, then the rectangle in row-major order.
    task automatic model(input int t, input int b, input int l, input int r,
                         input int c, input int g);
        exp_addr.delete();
        exp_data.delete();
        if (l > r || t > b || r >= 6 || b >= 6) begin
            exp_lat = 2;
            exp_err = 1;
            return;
        end
        for (int a = 0; a < 36; a++) begin
            exp_addr.push_back(a);
            exp_data.push_back(g);
        end
        for (int y = t; y <= b; y++)
            for (int x = l; x <= r; x++) begin
                exp_addr.push_back(y * 6 + x);
                exp_data.push_back(c);
            end
        exp_lat = 2 + 36 + (r - l + 1) * (b - t + 1);
        exp_err = 0;
    endtask

    // Issues one request and records what the DUT does; cyc = edges after the start edge.
    task automatic run_req(input int t, input int b, input int l, input int r,
                           input int c, input int g, input int pulse_at, input int rst_at);
        int cyc;
        @(negedge clk);
        bus.top = 3'(t); bus.bottom = 3'(b); bus.left = 3'(l); bus.right = 3'(r);
        bus.colour = 3'(c); bus.bg_colour = 3'(g); bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.top = 3'($urandom); bus.bottom = 3'($urandom);
        bus.left = 3'($urandom); bus.right = 3'($urandom);
        obs_addr.delete(); obs_data.delete();
        done_cyc = -1; ndone = 0; err_obs = -1; busy_after = -1;
        rst_wren = -1; rst_busy = -1; rst_done = -1;
        busy_start = int'(bus.busy);
        cyc = 0;
        while (cyc < 200) begin
            if (bus.mem_wren) begin
                obs_addr.push_back(int'(bus.mem_address));
                obs_data.push_back(int'(bus.mem_data));
            end
            if (bus.done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    err_obs  = int'(bus.err);
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                busy_after = int'(bus.busy);
                break;
            end
            if (rst_at >= 0 && cyc == rst_at + 6) break;
            if (cyc == pulse_at) begin
                bus.start = 1'b1;
                bus.top = 3'($urandom); bus.bottom = 3'($urandom);
                bus.left = 3'($urandom); bus.right = 3'($urandom);
            end
            if (cyc == rst_at) resetn = 1'b0;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (!resetn) begin
                rst_wren = int'(bus.mem_wren);
                rst_busy = int'(bus.busy);
                rst_done = int'(bus.done);
                resetn   = 1'b1;
            end
            cyc++;
        end
    endtask

    task automatic test_reset;
        n_checks++; if (bus.mem_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got %b want 0", bus.mem_wren); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.err); end
        n_checks++; if (bus.mem_address !== 6'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", bus.mem_address); end
        n_checks++; if (bus.mem_data !== 3'd0) begin n_fail++; $display("FAIL reset_data got %0d want 0", bus.mem_data); end
    endtask

    task automatic test_basic_rect;
        model(1, 3, 2, 4, 7, 0);
        run_req(1, 3, 2, 4, 7, 0, -1, -1);
        n_checks++; if (obs_addr.size() != 45) begin n_fail++; $display("FAIL basic_nwrites got %0d want 45", obs_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_checks++;
            if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) begin
                n_fail++; $display("FAIL basic_write[%0d] got %0d/%0d want %0d/%0d", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_checks++; if (done_cyc != 47) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 47", done_cyc); end
        n_checks++; if (err_obs != 0) begin n_fail++; $display("FAIL basic_err got %0d want 0", err_obs); end
        n_checks++; if (busy_start != 1 || busy_after != 0 || ndone != 1) begin
            n_fail++; $display("FAIL basic_busy_done got %0d/%0d/%0d want 1/0/1", busy_start, busy_after, ndone);
        end
    endtask

    task automatic test_one_by_one;
        model(5, 5, 5, 5, 3, 1);
        run_req(5, 5, 5, 5, 3, 1, -1, -1);
        n_checks++; if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL 1x1_nwrites got %0d want %0d", obs_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_checks++;
            if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) begin
                n_fail++; $display("FAIL 1x1_write[%0d] got %0d/%0d want %0d/%0d", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_checks++; if (done_cyc != 39 || err_obs != 0) begin n_fail++; $display("FAIL 1x1_done got cyc %0d err %0d want cyc 39 err 0", done_cyc, err_obs); end
    endtask

    task automatic test_invalid;
        run_req(0, 1, 4, 2, 5, 0, -1, -1);
        n_checks++; if (obs_addr.size() != 0) begin n_fail++; $display("FAIL inv_lr_writes got %0d want 0", obs_addr.size()); end
        n_checks++; if (done_cyc != 2 || err_obs != 1 || busy_after != 0) begin
            n_fail++; $display("FAIL inv_lr_done got cyc %0d err %0d busy %0d want 2/1/0", done_cyc, err_obs, busy_after);
        end
        run_req(2, 6, 0, 1, 5, 0, -1, -1);
        n_checks++; if (obs_addr.size() != 0) begin n_fail++; $display("FAIL inv_bot_writes got %0d want 0", obs_addr.size()); end
        n_checks++; if (done_cyc != 2 || err_obs != 1 || busy_after != 0) begin
            n_fail++; $display("FAIL inv_bot_done got cyc %0d err %0d busy %0d want 2/1/0", done_cyc, err_obs, busy_after);
        end
        model(0, 5, 0, 5, 6, 0);
        run_req(0, 5, 0, 5, 6, 0, -1, -1);
        n_checks++; if (obs_addr.size() != 72) begin n_fail++; $display("FAIL full_nwrites got %0d want 72", obs_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_checks++;
            if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) begin
                n_fail++; $display("FAIL full_write[%0d] got %0d/%0d want %0d/%0d", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_checks++; if (done_cyc != exp_lat || err_obs != 0) begin n_fail++; $display("FAIL full_done got cyc %0d err %0d want cyc %0d err 0", done_cyc, err_obs, exp_lat); end
    endtask

    task automatic test_start_while_busy;
        model(0, 2, 1, 3, 4, 2);
        run_req(0, 2, 1, 3, 4, 2, 10, -1);
        n_checks++; if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL busy_start_nwrites got %0d want %0d", obs_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_checks++;
            if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) begin
                n_fail++; $display("FAIL busy_start_write[%0d] got %0d/%0d want %0d/%0d", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_checks++; if (done_cyc != exp_lat || busy_after != 0) begin n_fail++; $display("FAIL busy_start_done got cyc %0d busy %0d want %0d/0", done_cyc, busy_after, exp_lat); end
        // A start landing in the FINISH cycle must not launch another request.
        model(3, 4, 0, 0, 2, 0);
        run_req(3, 4, 0, 0, 2, 0, exp_lat - 1, -1);
        n_checks++; if (done_cyc != exp_lat || busy_after != 0 || ndone != 1) begin
            n_fail++; $display("FAIL finish_start got cyc %0d busy %0d ndone %0d want %0d/0/1", done_cyc, busy_after, ndone, exp_lat);
        end
    endtask

    task automatic test_reset_mid_fill;
        model(0, 5, 0, 5, 5, 0);
        run_req(0, 5, 0, 5, 5, 0, -1, 39);
        n_checks++; if (obs_addr.size() != 39) begin n_fail++; $display("FAIL rst_nwrites got %0d want 39", obs_addr.size()); end
        for (int i = 0; i < 39 && i < obs_addr.size(); i++) begin
            n_checks++;
            if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) begin
                n_fail++; $display("FAIL rst_write[%0d] got %0d/%0d want %0d/%0d", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_checks++; if (rst_wren != 0 || rst_busy != 0 || rst_done != 0 || ndone != 0) begin
            n_fail++; $display("FAIL rst_state got wren %0d busy %0d done %0d ndone %0d want 0/0/0/0", rst_wren, rst_busy, rst_done, ndone);
        end
        model(1, 2, 3, 5, 1, 0);
        run_req(1, 2, 3, 5, 1, 0, -1, -1);
        n_checks++; if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL rst_after_nwrites got %0d want %0d", obs_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_checks++;
            if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) begin
                n_fail++; $display("FAIL rst_after_write[%0d] got %0d/%0d want %0d/%0d", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_checks++; if (done_cyc != exp_lat || err_obs != 0) begin n_fail++; $display("FAIL rst_after_done got cyc %0d err %0d want %0d/0", done_cyc, err_obs, exp_lat); end
    endtask

    task automatic test_random;
        int t, b, l, r, c, g, p;
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                l = $urandom_range(0, 5); r = $urandom_range(l, 5);
                t = $urandom_range(0, 5); b = $urandom_range(t, 5);
            end else begin
                l = $urandom_range(0, 7); r = $urandom_range(0, 7);
                t = $urandom_range(0, 7); b = $urandom_range(0, 7);
            end
            c = $urandom_range(0, 7);
            g = $urandom_range(0, 7);
            model(t, b, l, r, c, g);
            p = (exp_lat > 2) ? $urandom_range(0, exp_lat - 1) : -1;
            run_req(t, b, l, r, c, g, p, -1);
            n_checks++; if (obs_addr.size() != exp_addr.size()) begin
                n_fail++; $display("FAIL rand%0d_nwrites got %0d want %0d", n, obs_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
                n_checks++;
                if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) begin
                    n_fail++; $display("FAIL rand%0d_write[%0d] got %0d/%0d want %0d/%0d", n, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
                end
            end
            n_checks++; if (done_cyc != exp_lat || err_obs != exp_err || busy_after != 0 || ndone != 1) begin
                n_fail++; $display("FAIL rand%0d_done got cyc %0d err %0d busy %0d ndone %0d want %0d/%0d/0/1",
                                   n, done_cyc, err_obs, busy_after, ndone, exp_lat, exp_err);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.top = '0; bus.bottom = '0; bus.left = '0; bus.right = '0;
        bus.colour = '0; bus.bg_colour = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        resetn = 1'b1;
        test_basic_rect();
        test_one_by_one();
        test_invalid();
        test_start_while_busy();
        test_reset_mid_fill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
